// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pkg
// Shared read-mode constants and the count-width helper for the FIFO family.
// Rev    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Width needed to hold every occupancy value 0..depth inclusive.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_wrap.sv
`default_nettype none
// ============================================================================
// Module : fifo_ptr_wrap
// DEPTH-modulo pointer incrementer; valid for any DEPTH, not only powers of 2.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [PW-1:0] i_ptr,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr_nxt
);

    localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);

    always_comb begin
        o_ptr_nxt = i_ptr;
        if (i_inc) begin
            o_ptr_nxt = (i_ptr == c_last) ? '0 : i_ptr + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_mem_prog.sv
`default_nettype none
// ============================================================================
// Module : fifo_mem_prog
// Single-clock FIFO: any depth, STD/FWFT read, live thresholds, sticky errors.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_mem_prog
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int FWFT   = FIFO_STD,
    parameter int CW     = fifo_cw(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    input  logic              clr_err_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CW-1:0]     af_thresh_i,
    input  logic [CW-1:0]     ae_thresh_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              overflow,
    output logic              underflow,
    output logic              ovf_sticky_o,
    output logic              udf_sticky_o
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic [PW-1:0]     w_rd_ptr_nxt;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_ovf;
    logic              r_udf;
    logic              r_ovs;
    logic              r_uds;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ovf_nxt;
    logic              w_udf_nxt;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth);
    // A read on a full FIFO frees the slot the concurrent write needs.
    assign w_rd_acc = rd_en_i && !w_empty;
    assign w_wr_acc = wr_en_i && (!w_full || w_rd_acc);

    // Requests arriving during a flush are dropped silently.
    assign w_ovf_nxt = !flush_i && wr_en_i && !w_wr_acc;
    assign w_udf_nxt = !flush_i && rd_en_i && !w_rd_acc;

    fifo_ptr_wrap #(
        .DEPTH     (DEPTH),
        .PW        (PW)
    ) u_wr_ptr (
        .i_ptr     (r_wr_ptr),
        .i_inc     (w_wr_acc),
        .o_ptr_nxt (w_wr_ptr_nxt)
    );

    fifo_ptr_wrap #(
        .DEPTH     (DEPTH),
        .PW        (PW)
    ) u_rd_ptr (
        .i_ptr     (r_rd_ptr),
        .i_inc     (w_rd_acc),
        .o_ptr_nxt (w_rd_ptr_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst && !flush_i && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_ovs    <= 1'b0;
            r_uds    <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
            r_udf <= w_udf_nxt;
            // A fresh error beats a simultaneous clear.
            r_ovs <= w_ovf_nxt | (r_ovs & ~clr_err_i);
            r_uds <= w_udf_nxt | (r_uds & ~clr_err_i);
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_valid  <= 1'b0;
            end else begin
                r_wr_ptr <= w_wr_ptr_nxt;
                r_rd_ptr <= w_rd_ptr_nxt;
                r_valid  <= w_rd_acc;
                if (w_rd_acc) begin
                    r_data <= r_mem[r_rd_ptr];
                end
                case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // While empty, show the last popped word instead of stale storage.
            assign data_o  = w_empty ? r_data : r_mem[r_rd_ptr];
            assign valid_o = !w_empty;
        end else begin : g_std
            assign data_o  = r_data;
            assign valid_o = r_valid;
        end
    endgenerate

    assign count_o        = r_count;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (af_thresh_i == '0) || (r_count >= af_thresh_i);
    assign almost_empty_o = (ae_thresh_i >= c_depth) || (r_count <= ae_thresh_i);
    assign overflow       = r_ovf;
    assign underflow      = r_udf;
    assign ovf_sticky_o   = r_ovs;
    assign udf_sticky_o   = r_uds;

endmodule
`default_nettype wire

// File: tb/tb_fifo_mem_prog.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_mem_prog
// Self-checking bench: STD and FWFT instances (DEPTH=6) against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_mem_prog;

    localparam int D = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] af = 3'd0;
    logic [2:0] ae = 3'd1;

    logic [7:0] s_data, f_data;
    logic       s_valid, f_valid, s_full, f_full, s_empty, f_empty;
    logic [2:0] s_count, f_count;
    logic       s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
    logic       s_ovs, f_ovs, s_uds, f_uds;

    always #5 clk = ~clk;

    fifo_mem_prog #(.DATA_W(8), .DEPTH(D), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .flush_i(flush),
        .clr_err_i(clr), .data_i(din), .af_thresh_i(af), .ae_thresh_i(ae),
        .data_o(s_data), .valid_o(s_valid), .count_o(s_count), .full_o(s_full),
        .empty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae),
        .overflow(s_ovf), .underflow(s_udf), .ovf_sticky_o(s_ovs), .udf_sticky_o(s_uds)
    );

    fifo_mem_prog #(.DATA_W(8), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .rd_en_i(rd_en), .flush_i(flush),
        .clr_err_i(clr), .data_i(din), .af_thresh_i(af), .ae_thresh_i(ae),
        .data_o(f_data), .valid_o(f_valid), .count_o(f_count), .full_o(f_full),
        .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae),
        .overflow(f_ovf), .underflow(f_udf), .ovf_sticky_o(f_ovs), .udf_sticky_o(f_uds)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: occupancy is the queue, errors follow the accept rules.
    int         q[$];
    bit         model_on = 1'b0;
    bit         rd_ok, wr_ok;
    bit         m_valid, m_ovf, m_udf, m_ovs, m_uds;
    logic [7:0] m_data;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            m_valid = 0; m_ovf = 0; m_udf = 0; m_ovs = 0; m_uds = 0;
            m_data = 8'h00;
            model_on = 1'b1;
        end else if (flush) begin
            q.delete();
            m_valid = 0; m_ovf = 0; m_udf = 0;
            m_ovs = m_ovs & !clr;
            m_uds = m_uds & !clr;
        end else begin
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && ((q.size() < D) || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_data = 8'(q.pop_front());
            if (wr_ok) q.push_back(int'(din));
            m_ovf = wr_en && !wr_ok;
            m_udf = rd_en && !rd_ok;
            m_ovs = m_ovf | (m_ovs & !clr);
            m_uds = m_udf | (m_uds & !clr);
        end
    end

    int n;
    always @(negedge clk) begin
        if (model_on) begin
            n = q.size();
            chk("s_count", 32'(s_count), 32'(n));
            chk("f_count", 32'(f_count), 32'(n));
            chk("s_full",  32'(s_full),  32'(n == D));
            chk("s_empty", 32'(s_empty), 32'(n == 0));
            chk("s_af",    32'(s_af),    32'((af == 0) || (n >= int'(af))));
            chk("s_ae",    32'(s_ae),    32'((int'(ae) >= D) || (n <= int'(ae))));
            chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
            chk("s_udf",   32'(s_udf),   32'(m_udf));
            chk("s_ovs",   32'(s_ovs),   32'(m_ovs));
            chk("s_uds",   32'(s_uds),   32'(m_uds));
            chk("f_ovs",   32'(f_ovs),   32'(m_ovs));
            chk("s_valid", 32'(s_valid), 32'(m_valid));
            chk("s_data",  32'(s_data),  32'(m_data));
            chk("f_valid", 32'(f_valid), 32'(n > 0));
            chk("f_data",  32'(f_data),  (n > 0) ? 32'(q[0]) : 32'(m_data));
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [7:0] d);
        wr_en = w; rd_en = r; din = d;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        // Reset with af=0: almost_full forced high even at count 0.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(s_count), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_full",  32'(s_full), 0);
        chk("rst_af0",   32'(s_af), 1);
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_data",  32'(s_data), 0);
        chk("rst_fvalid", 32'(f_valid), 0);
        rst = 1'b1;
        af  = 3'd4;

        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h10 + 8'(i));
        chk("fill_count", 32'(s_count), 6);
        chk("fill_full",  32'(s_full), 1);
        cyc(1, 0, 8'h99);
        chk("ovf_pulse", 32'(s_ovf), 1);
        chk("ovf_stick", 32'(s_ovs), 1);
        chk("ovf_count", 32'(s_count), 6);
        cyc(0, 0, 8'h00);
        chk("ovf_drop",  32'(s_ovf), 0);

        for (int i = 0; i < 6; i++) begin
            chk("fwft_head", 32'(f_data), 32'(8'h10 + 8'(i)));
            cyc(0, 1, 8'h00);
            chk("rd_data",  32'(s_data), 32'(8'h10 + 8'(i)));
            chk("rd_valid", 32'(s_valid), 1);
        end
        cyc(0, 1, 8'h00);
        chk("udf_pulse", 32'(s_udf), 1);
        chk("udf_stick", 32'(s_uds), 1);
        cyc(0, 0, 8'h00);
        chk("valid_one_cycle", 32'(s_valid), 0);
        clr = 1'b1;
        cyc(0, 0, 8'h00);
        clr = 1'b0;
        chk("clr_ovs", 32'(s_ovs), 0);
        chk("clr_uds", 32'(s_uds), 0);

        // Read+write on empty: write lands, read is rejected.
        cyc(1, 1, 8'h20);
        chk("emp_rw_count", 32'(s_count), 1);
        chk("emp_rw_udf",   32'(s_udf), 1);
        chk("fwft_vis",     32'(f_data), 32'h20);
        cyc(0, 1, 8'h00);
        chk("emp_rw_data",  32'(s_data), 32'h20);

        // Pointer wrap across index 5 -> 0.
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 8'h00);
            chk("wrap_a", 32'(s_data), 32'(8'h30 + 8'(i)));
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h40 + 8'(i));
        chk("wrap_count", 32'(s_count), 5);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'h00);
            chk("wrap_b", 32'(s_data), 32'(8'h40 + 8'(i)));
            chk("wrap_cnt", 32'(s_count), 32'(4 - i));
        end

        // Thresholds af=4, ae=1.
        cyc(1, 0, 8'h50);
        chk("ae_at1", 32'(s_ae), 1);
        chk("af_at1", 32'(s_af), 0);
        cyc(1, 0, 8'h51);
        chk("ae_at2", 32'(s_ae), 0);
        cyc(1, 0, 8'h52);
        cyc(1, 0, 8'h53);
        chk("af_at4", 32'(s_af), 1);
        af = 3'd5;
        #1;
        chk("af_live", 32'(s_af), 0);
        cyc(1, 0, 8'h54);
        cyc(1, 0, 8'h55);
        cyc(1, 1, 8'h56);
        chk("full_rw_count", 32'(s_count), 6);
        chk("full_rw_ovf",   32'(s_ovf), 0);
        chk("full_rw_data",  32'(s_data), 32'h50);

        // Flush with 3 entries; concurrent write is ignored.
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00);
        chk("pre_flush", 32'(s_count), 3);
        flush = 1'b1;
        cyc(1, 0, 8'h77);
        flush = 1'b0;
        chk("fl_count", 32'(s_count), 0);
        chk("fl_empty", 32'(f_empty), 1);
        chk("fl_uds",   32'(s_uds), 1);
        chk("fl_ovf",   32'(s_ovf), 0);

        cyc(1, 0, 8'hA5);
        chk("fwft_a5",    32'(f_data), 32'hA5);
        chk("fwft_valid", 32'(f_valid), 1);
        chk("std_novalid", 32'(s_valid), 0);

        // Reset mid-burst.
        cyc(1, 0, 8'hB0);
        cyc(1, 0, 8'hB1);
        rst = 1'b0;
        cyc(1, 0, 8'hB2);
        chk("mrst_count", 32'(f_count), 0);
        chk("mrst_empty", 32'(s_empty), 1);
        chk("mrst_uds",   32'(s_uds), 0);
        chk("mrst_data",  32'(s_data), 0);
        chk("mrst_fdata", 32'(f_data), 0);
        chk("mrst_fval",  32'(f_valid), 0);
        rst = 1'b1;
        cyc(0, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
